// File: rtl/obi_core_port_arbiter.sv
// Two-port OBI arbiter merging core instruction (port 0) and data (port 1) onto one bus.
// Define OBI_ARB_DATA_FIXED_PRIO_EN to give the data port fixed priority instead of round-robin.
package obi_core_port_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_core_port_arbiter
  import obi_core_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  instr_req_i,
  output obi_resp_t instr_resp_o,
  input  obi_req_t  data_req_i,
  output obi_resp_t data_resp_o,
  output obi_req_t  mst_req_o,
  input  obi_resp_t mst_resp_i,
  output logic      idle_o,
  output logic      resp_err_o
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  logic                       rr_q;
  logic                       lock_q;
  logic                       sel_q;
  logic                       resp_err_q;
  logic [CntW-1:0]            count_q;
  logic [PtrW-1:0]            wptr_q;
  logic [PtrW-1:0]            rptr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;

  logic sel;
  logic sel_req;
  logic full;
  logic empty;
  logic mst_valid;
  logic grant;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // sel: 0 = instr port, 1 = data port
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = sel_q;
    end else begin
`ifdef OBI_ARB_DATA_FIXED_PRIO_EN
      sel = data_req_i.req;
`else
      if (instr_req_i.req && data_req_i.req) sel = ~rr_q;
      else                                   sel = data_req_i.req;
`endif
    end
  end

  assign sel_req   = sel ? data_req_i.req : instr_req_i.req;
  assign full      = (count_q == CntMax);
  assign empty     = (count_q == '0);
  assign mst_valid = sel_req & ~full & ~rst_i;
  assign grant     = mst_resp_i.gnt & mst_valid;
  assign pop       = mst_resp_i.rvalid & ~empty & ~rst_i;
  assign head      = fifo_q[rptr_q];

  always_comb begin
    mst_req_o     = sel ? data_req_i : instr_req_i;
    mst_req_o.req = mst_valid;
  end

  always_comb begin
    instr_resp_o.gnt    = grant & ~sel;
    instr_resp_o.rvalid = pop & ~head;
    instr_resp_o.rdata  = mst_resp_i.rdata;
    data_resp_o.gnt     = grant & sel;
    data_resp_o.rvalid  = pop & head;
    data_resp_o.rdata   = mst_resp_i.rdata;
  end

  assign idle_o     = empty & ~instr_req_i.req & ~data_req_i.req;
  assign resp_err_o = resp_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= 1'b1;
      lock_q     <= 1'b0;
      sel_q      <= 1'b0;
      resp_err_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_q     <= '0;
    end else begin
      resp_err_q <= mst_resp_i.rvalid & empty;
      if (grant) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= ptr_next(wptr_q);
        rr_q           <= sel;
      end
      if (pop) rptr_q <= ptr_next(rptr_q);
      unique case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Hold the pick while a request waits for gnt so the address stays stable.
      if (mst_valid && !mst_resp_i.gnt) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end else begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_obi_core_port_arbiter.sv
// Directed bench for obi_core_port_arbiter (MAX_OUTSTANDING=2).
module tb_obi_core_port_arbiter;
  import obi_core_port_arbiter_pkg::*;

  logic      clk;
  logic      rst;
  obi_req_t  instr_req;
  obi_resp_t instr_resp;
  obi_req_t  data_req;
  obi_resp_t data_resp;
  obi_req_t  mst_req;
  obi_resp_t mst_resp;
  logic      idle;
  logic      resp_err;

  int total = 0;
  int bad   = 0;

  obi_core_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_req_i  (instr_req),
    .instr_resp_o (instr_resp),
    .data_req_i   (data_req),
    .data_resp_o  (data_resp),
    .mst_req_o    (mst_req),
    .mst_resp_i   (mst_resp),
    .idle_o       (idle),
    .resp_err_o   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req = '0;
    data_req  = '0;
    mst_resp  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    instr_req.req = 1'b1;
    data_req.req  = 1'b1;
    mst_resp.gnt  = 1'b1;
    mst_resp.rvalid = 1'b1;
    @(negedge clk);
    total++; if (mst_req.req !== 1'b0) begin bad++; $display("FAIL rst_mst_req got=%b exp=0", mst_req.req); end
    total++; if (instr_resp.gnt !== 1'b0 || data_resp.gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", instr_resp.gnt, data_resp.gnt); end
    total++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", instr_resp.rvalid, data_resp.rvalid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    clear_inputs();
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_instr;
`ifdef OBI_ARB_DATA_FIXED_PRIO_EN
    exp_instr = 4'b0001;
`else
    exp_instr = 4'b0101;
`endif
    instr_req.req = 1'b1;
    instr_req.addr = 32'h0000_0010;
    data_req.req  = 1'b1;
    data_req.addr = 32'h0000_0020;
`ifdef OBI_ARB_DATA_FIXED_PRIO_EN
    data_req.req  = 1'b0;
`endif
    mst_resp.gnt  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (instr_resp.gnt !== exp_instr[c] || data_resp.gnt !== ~exp_instr[c]) begin
        bad++; $display("FAIL rr_grant%0d got=i%b d%b exp=i%b d%b", c, instr_resp.gnt, data_resp.gnt, exp_instr[c], ~exp_instr[c]);
      end
      if (c > 0) begin
        total++; if (instr_resp.rvalid !== exp_instr[c-1] || data_resp.rvalid !== ~exp_instr[c-1]) begin
          bad++; $display("FAIL rr_rvalid%0d got=i%b d%b exp=i%b d%b", c, instr_resp.rvalid, data_resp.rvalid, exp_instr[c-1], ~exp_instr[c-1]);
        end
      end
      tick();
      data_req.req    = 1'b1;
      mst_resp.rvalid = 1'b1;
    end
    instr_req.req = 1'b0;
    data_req.req  = 1'b0;
    mst_resp.gnt  = 1'b0;
    @(negedge clk);
    total++; if (data_resp.rvalid !== 1'b1 || instr_resp.rvalid !== 1'b0) begin
      bad++; $display("FAIL rr_last_rvalid got=i%b d%b exp=i0 d1", instr_resp.rvalid, data_resp.rvalid);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rr_idle got=%b exp=1", idle); end
    tick();
  endtask

  task automatic test_lock();
    data_req.req  = 1'b1;
    data_req.addr = 32'h0000_0100;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin instr_req.req = 1'b1; instr_req.addr = 32'h0000_0200; end
      mst_resp.gnt = (c == 4);
      @(negedge clk);
      total++; if (mst_req.addr !== 32'h0000_0100 || mst_req.req !== 1'b1) begin
        bad++; $display("FAIL lock_addr%0d got=%h req=%b exp=00000100 req=1", c, mst_req.addr, mst_req.req);
      end
      total++; if (data_resp.gnt !== (c == 4) || instr_resp.gnt !== 1'b0) begin
        bad++; $display("FAIL lock_gnt%0d got=i%b d%b exp=i0 d%b", c, instr_resp.gnt, data_resp.gnt, (c == 4));
      end
      tick();
    end
    clear_inputs();
    mst_resp.rvalid = 1'b1;
    @(negedge clk);
    total++; if (data_resp.rvalid !== 1'b1 || instr_resp.rvalid !== 1'b0) begin
      bad++; $display("FAIL lock_rvalid got=i%b d%b exp=i0 d1", instr_resp.rvalid, data_resp.rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_full();
    instr_req.req  = 1'b1;
    instr_req.addr = 32'h0000_0300;
    mst_resp.gnt   = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++; if (instr_resp.gnt !== 1'b1) begin bad++; $display("FAIL full_gnt%0d got=%b exp=1", c, instr_resp.gnt); end
      tick();
    end
    @(negedge clk);
    total++; if (mst_req.req !== 1'b0 || instr_resp.gnt !== 1'b0) begin
      bad++; $display("FAIL full_block got=req%b gnt%b exp=req0 gnt0", mst_req.req, instr_resp.gnt);
    end
    tick();
    mst_resp.rvalid = 1'b1;
    @(negedge clk);
    total++; if (mst_req.req !== 1'b0) begin bad++; $display("FAIL full_block_rvalid got=%b exp=0", mst_req.req); end
    total++; if (instr_resp.rvalid !== 1'b1) begin bad++; $display("FAIL full_pop got=%b exp=1", instr_resp.rvalid); end
    tick();
    mst_resp.rvalid = 1'b0;
    @(negedge clk);
    total++; if (mst_req.req !== 1'b1 || instr_resp.gnt !== 1'b1) begin
      bad++; $display("FAIL full_resume got=req%b gnt%b exp=req1 gnt1", mst_req.req, instr_resp.gnt);
    end
    tick();
    clear_inputs();
    mst_resp.rvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (instr_resp.rvalid !== 1'b1) begin bad++; $display("FAIL full_drain%0d got=%b exp=1", c, instr_resp.rvalid); end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL full_idle got=%b exp=1", idle); end
    tick();
  endtask

  task automatic test_rdata();
    instr_req.req   = 1'b1;
    instr_req.addr  = 32'h0000_0400;
    instr_req.we    = 1'b0;
    instr_req.be    = 4'b1111;
    instr_req.wdata = 32'h0;
    mst_resp.gnt    = 1'b1;
    @(negedge clk);
    total++; if (mst_req.we !== 1'b0 || mst_req.be !== 4'b1111 || mst_req.wdata !== 32'h0 || instr_resp.gnt !== 1'b1) begin
      bad++; $display("FAIL rd_instr_fields got=we%b be%b wd%h gnt%b exp=we0 be1111 wd00000000 gnt1", mst_req.we, mst_req.be, mst_req.wdata, instr_resp.gnt);
    end
    tick();
    instr_req      = '0;
    data_req.req   = 1'b1;
    data_req.addr  = 32'h0000_0500;
    data_req.we    = 1'b1;
    data_req.be    = 4'b0011;
    data_req.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (mst_req.addr !== 32'h0000_0500 || mst_req.we !== 1'b1 || mst_req.be !== 4'b0011 || mst_req.wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd_data_fields got=a%h we%b be%b wd%h exp=a00000500 we1 be0011 wddeadbeef", mst_req.addr, mst_req.we, mst_req.be, mst_req.wdata);
    end
    total++; if (data_resp.gnt !== 1'b1 || instr_resp.gnt !== 1'b0) begin
      bad++; $display("FAIL rd_data_gnt got=i%b d%b exp=i0 d1", instr_resp.gnt, data_resp.gnt);
    end
    tick();
    clear_inputs();
    mst_resp.rvalid = 1'b1;
    mst_resp.rdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    total++; if (instr_resp.rvalid !== 1'b1 || data_resp.rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_first_route got=i%b d%b exp=i1 d0", instr_resp.rvalid, data_resp.rvalid);
    end
    total++; if (instr_resp.rdata !== 32'hA5A5_A5A5 || data_resp.rdata !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL rd_first_data got=i%h d%h exp=a5a5a5a5", instr_resp.rdata, data_resp.rdata);
    end
    tick();
    mst_resp.rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    total++; if (data_resp.rvalid !== 1'b1 || instr_resp.rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_second_route got=i%b d%b exp=i0 d1", instr_resp.rvalid, data_resp.rvalid);
    end
    total++; if (data_resp.rdata !== 32'h5A5A_5A5A) begin
      bad++; $display("FAIL rd_second_data got=%h exp=5a5a5a5a", data_resp.rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_resp_err();
    mst_resp.rvalid = 1'b1;
    @(negedge clk);
    total++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL err_empty_rvalid got=i%b d%b err%b exp=i0 d0 err0", instr_resp.rvalid, data_resp.rvalid, resp_err);
    end
    tick();
    mst_resp.rvalid = 1'b0;
    @(negedge clk);
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", resp_err); end
    tick();
    @(negedge clk);
    total++; if (resp_err !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL err_pulse_end got=err%b idle%b exp=err0 idle1", resp_err, idle);
    end
    tick();
    instr_req.req = 1'b1;
    mst_resp.gnt  = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL err_outstanding_idle got=%b exp=0", idle); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (idle !== 1'b1 || mst_req.req !== 1'b0) begin
      bad++; $display("FAIL err_async_rst got=idle%b req%b exp=idle1 req0", idle, mst_req.req);
    end
    tick();
    rst = 1'b0;
    mst_resp.rvalid = 1'b1;
    @(negedge clk);
    total++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0) begin
      bad++; $display("FAIL err_post_rst_route got=i%b d%b exp=i0 d0", instr_resp.rvalid, data_resp.rvalid);
    end
    tick();
    mst_resp.rvalid = 1'b0;
    @(negedge clk);
    total++; if (resp_err !== 1'b1 || idle !== 1'b1) begin
      bad++; $display("FAIL err_post_rst_pulse got=err%b idle%b exp=err1 idle1", resp_err, idle);
    end
    tick();
    @(negedge clk);
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL err_post_rst_end got=%b exp=0", resp_err); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_rdata();
    test_resp_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_core_port_arbiter.md
OBI_CORE_PORT_ARBITER -- requirements
Module: obi_core_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted requests awaiting rvalid (range 1..4).
REQ-002 SHALL have port clk_i  input  1  clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port instr_req_i  input  obi_req_t  core instruction request (port 0).
REQ-005 SHALL have port instr_resp_o  output  obi_resp_t  response to port 0.
REQ-006 SHALL have port data_req_i  input  obi_req_t  core data request (port 1).
REQ-007 SHALL have port data_resp_o  output  obi_resp_t  response to port 1.
REQ-008 SHALL have port mst_req_o  output  obi_req_t  merged request to the memory bus.
REQ-009 SHALL have port mst_resp_i  input  obi_resp_t  memory bus response.
REQ-010 SHALL have port idle_o  output  1  high when nothing is outstanding and no port requests.
REQ-011 SHALL have port resp_err_o  output  1  one-cycle pulse on an unexpected rvalid.

Function
REQ-012 SHALL forward the addr, we, be and wdata of exactly one selected port to mst_req_o, with mst_req_o.req = selected port req AND NOT full.
REQ-013 SHALL select by round-robin: the port not granted last wins when both request; a lone requester wins. rr_q records the last granted port.
REQ-014 SHALL lock the selection while mst_req_o.req=1 and mst_resp_i.gnt=0; the lock clears on gnt so the address stays stable (OBI).
REQ-015 SHALL drive gnt combinationally only to the selected port: gnt = mst_resp_i.gnt AND mst_req_o.req; the other port gets gnt=0.
REQ-016 SHALL push the selected port id into a FIFO of depth MAX_OUTSTANDING on each granted transfer, with zero added latency.
REQ-017 SHALL route mst_resp_i.rvalid to the port at the FIFO head only and pop it; rdata SHALL be broadcast to both ports.
REQ-018 SHALL hold mst_req_o.req=0 when count==MAX_OUTSTANDING (full), even if rvalid arrives in that cycle.
REQ-019 SHALL keep count unchanged on a simultaneous grant and rvalid (push and pop in the same cycle); pointers wrap modulo MAX_OUTSTANDING.
REQ-020 SHALL, on rvalid with an empty FIFO, forward no rvalid, pulse resp_err_o for one cycle and leave state unchanged.
REQ-021 SHALL drive idle_o = (count==0) AND NOT instr_req_i.req AND NOT data_req_i.req.
REQ-022 SHALL honour port 0 write fields as driven (wdata=0, we=0, be=4'b1111 expected) without overriding them.

Reset
REQ-023 SHALL, while rst_i=1, clear count, FIFO pointers, lock and resp_err_o, and set rr_q=1 (data) so instr wins the first contention.
REQ-024 SHALL discard all outstanding entries on reset mid-operation; subsequent rvalids are treated per REQ-020.
REQ-025 SHALL drive all gnt/rvalid outputs and mst_req_o.req low during reset.

Configuration
REQ-026 SHALL, with macro OBI_ARB_DATA_FIXED_PRIO_EN defined, give port 1 (data) fixed priority over port 0 whenever the selection is unlocked; rr_q is unused.
REQ-027 SHALL, without OBI_ARB_DATA_FIXED_PRIO_EN, use round-robin per REQ-013.

Verification
REQ-028 Both ports request every cycle with gnt=1, rvalid 1 cycle later: first 4 grants are instr, data, instr, data (round-robin build); instr, data, data, data (fixed-priority build).
REQ-029 Data requests addr 0x100 with gnt=0 for 3 cycles while instr requests: mst_req_o.addr stays 0x100 and the data port gets the grant on cycle 4.
REQ-030 MAX_OUTSTANDING=2, two grants, rvalid withheld: third request sees mst_req_o.req=0 until the first rvalid, then forwards on the next cycle.
REQ-031 Grant instr then data, rvalids return rdata 0xA5A5A5A5 then 0x5A5A5A5A: instr_resp_o.rvalid first, then data_resp_o.rvalid, rdata matching.
REQ-032 rvalid with count==0: no port rvalid, resp_err_o=1 for exactly 1 cycle; assert rst_i with 1 outstanding, then rvalid: resp_err_o pulses, idle_o=1.
